program_loader: RTL and testbench
=================================

# program_loader

Boot-time front end for the single-cycle RiSC-16 core. It accepts a length-prefixed stream of 16-bit instruction words over a valid/ready handshake and writes them sequentially into the instruction memory's write port. While loading, it holds the core (program counter and downstream state) in reset. It releases the core only after the last word is committed, so the PC starts at 0 with a fully populated instruction memory.

## Interface
Parameters:
- ADDR_W, default 8: instruction memory address width; depth DEPTH = 2^ADDR_W words.
- WORD_W, default 16: instruction word width. Fixed at 16 for RiSC-16; the parameter exists for the bench.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word available.
- in_data  in  WORD_W  upstream word.
- in_ready  out  1  loader can accept; a transfer occurs on a rising edge with in_valid && in_ready.
- im_we  out  1  instruction memory write enable, one cycle per word.
- im_addr  out  ADDR_W  instruction memory write address.
- im_wdata  out  WORD_W  instruction memory write data.
- cpu_rst  out  1  reset to PC/core; high until the load completes.
- done  out  1  load completed successfully; sticky until reset.
- err  out  1  malformed stream; sticky until reset.

## Operation
- All outputs are registered.
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, done=0, err=0, state=S_LEN.
- States: S_LEN, S_LOAD, S_FLUSH, S_DONE, S_ERR.
- **S_LEN**
  - in_ready=1 from the first cycle after reset deasserts.
  - The first accepted word is the length N, treated as unsigned WORD_W.
  - If 1 ≤ N ≤ DEPTH: store remaining=N (ADDR_W+1 bits) and index=0, then go to S_LOAD.
  - Otherwise: go to S_ERR. No memory write occurs.
- **S_LOAD**
  - in_ready=1.
  - Each accepted word drives im_we=1, im_addr=index, im_wdata=in_data on the next cycle; then index++ and remaining--.
  - Cycles without a transfer drive im_we=0; im_addr and im_wdata hold their last values.
  - On the accept that brings remaining to 0, go to S_FLUSH. in_ready drops in the same registered update.
- **S_FLUSH**
  - One cycle; the last word's im_we pulse is visible here.
  - in_ready=0.
  - Then go to S_DONE.
- **S_DONE**
  - in_ready=0, cpu_rst=0, done=1, im_we=0.
  - Held until reset. Further in_valid is ignored.
- **S_ERR**
  - in_ready=0, cpu_rst=1, err=1, im_we=0.
  - Held until reset.
- index never wraps: N ≤ DEPTH, so the last address is N-1 ≤ DEPTH-1.
- Reset mid-load: the next cycle is in the reset state and in_ready=0. Words already written remain in memory but are overwritten by the next load starting at address 0.
- done and err are mutually exclusive.

## Timing
- A word accepted at edge k appears on im_we/im_addr/im_wdata during cycle k+1; the memory captures it at edge k+2.
- The final data word is accepted at edge k. Then S_FLUSH occupies cycle k+1, and cpu_rst=0 and done=1 from cycle k+2 onward.
- The core's first fetch (PC=0) follows cpu_rst deassertion.
- Throughput: one word per cycle with in_valid held high. The loader never stalls in S_LEN or S_LOAD.
- Bad length accepted at edge k: err=1 and in_ready=0 from cycle k+1.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the N data words, the loader requires one trailer word in an extra state S_CSUM (in_ready=1).
  - Data words are summed modulo 2^16, excluding the length word.
  - Trailer == sum: go to S_FLUSH, then S_DONE.
  - Mismatch: go to S_ERR. Memory writes already made stand; cpu_rst stays 1.
  - Done latency is measured from the trailer accept (k+2).
- LOADER_CHECKSUM_EN undefined:
  - No trailer and no S_CSUM.
  - The word after the Nth is not accepted (in_ready=0).

## Test plan
- Happy path:
  - Stimulus: N=3, then 0x1234, 0xABCD, 0x0001 with valid every cycle.
  - Response: im_we pulses on 3 consecutive cycles at addr 0, 1, 2 with matching data; done=1 and cpu_rst=0 two cycles after the last accept.
- Backpressure and gaps:
  - Stimulus: same stream with in_valid low on alternate cycles.
  - Response: im_we only in cycles following accepts; addresses 0, 1, 2 with no skips; no write on idle cycles.
- Bad length:
  - Stimulus: N=0, and separately N=257 (ADDR_W=8).
  - Response: err=1 and in_ready=0 from the next cycle; cpu_rst stays 1; no im_we pulse.
- Full depth:
  - Stimulus: N=256 with words 0..255.
  - Response: last write at addr 255 with data 255; done=1; no address wrap.
- Reset mid-load:
  - Stimulus: N=5, two words accepted, then reset for 1 cycle, then N=1, 0xBEEF.
  - Response: outputs at reset values during reset; the new load writes 0xBEEF at addr 0; done=1.
- LOADER_CHECKSUM_EN:
  - Stimulus: N=3, 0x1234, 0xABCD, 0x0001, trailer 0xBE02.
  - Response: done=1.
  - Stimulus: same stream with trailer 0xBE03.
  - Response: err=1, cpu_rst=1.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: takes a length-prefixed word stream and writes it into instruction memory, holding the core in reset until the load completes.
// Define LOADER_CHECKSUM_EN to require a trailer word equal to the modulo-2^16 sum of the data words.
//
// state   | meaning
// S_LEN   | waiting for the length word
// S_LOAD  | accepting data words, one memory write per accept
// S_CSUM  | waiting for the checksum trailer (LOADER_CHECKSUM_EN only)
// S_FLUSH | one cycle after the final accept, before release
// S_DONE  | load complete, core released (sticky)
// S_ERR   | malformed stream, core held in reset (sticky)
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_LOAD, S_CSUM, S_FLUSH, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN, S_LOAD, S_FLUSH, S_DONE, S_ERR} state_t;
`endif

  state_t state, state_nxt;

  logic [ADDR_W:0]   remaining, remaining_nxt;
  logic [ADDR_W-1:0] index, index_nxt;
  logic              in_ready_nxt, im_we_nxt, cpu_rst_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0] im_addr_nxt;
  logic [WORD_W-1:0] im_wdata_nxt;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum, sum_nxt;
`endif

  logic accept, len_ok, last_word;

  // in_ready is registered, so it already encodes whether the current state accepts.
  assign accept    = in_valid && in_ready;
  assign len_ok    = (in_data != '0) && (32'(in_data) <= DEPTH);
  assign last_word = (remaining == (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_LEN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN:   if (accept) state_nxt = len_ok ? S_LOAD : S_ERR;
      S_LOAD:  if (accept && last_word) begin
`ifdef LOADER_CHECKSUM_EN
        state_nxt = S_CSUM;
`else
        state_nxt = S_FLUSH;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:  if (accept) state_nxt = (in_data == sum) ? S_FLUSH : S_ERR;
`endif
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  // Outputs are computed from the next state so that every port comes straight from a flop.
  always_comb begin
`ifdef LOADER_CHECKSUM_EN
    in_ready_nxt = (state_nxt == S_LEN) || (state_nxt == S_LOAD) || (state_nxt == S_CSUM);
    sum_nxt      = sum;
`else
    in_ready_nxt = (state_nxt == S_LEN) || (state_nxt == S_LOAD);
`endif
    im_we_nxt     = 1'b0;
    im_addr_nxt   = im_addr;
    im_wdata_nxt  = im_wdata;
    cpu_rst_nxt   = (state_nxt != S_DONE);
    done_nxt      = (state_nxt == S_DONE);
    err_nxt       = (state_nxt == S_ERR);
    remaining_nxt = remaining;
    index_nxt     = index;
    if (accept) begin
      if (state == S_LEN) begin
        remaining_nxt = in_data[ADDR_W:0];
        index_nxt     = '0;
`ifdef LOADER_CHECKSUM_EN
        sum_nxt       = '0;
`endif
      end else if (state == S_LOAD) begin
        im_we_nxt     = 1'b1;
        im_addr_nxt   = index;
        im_wdata_nxt  = in_data;
        remaining_nxt = remaining - 1'b1;
        // Hold index on the final word so a full-depth load never wraps it.
        if (!last_word) index_nxt = index + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum_nxt       = sum + in_data;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      index     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      in_ready  <= in_ready_nxt;
      im_we     <= im_we_nxt;
      im_addr   <= im_addr_nxt;
      im_wdata  <= im_wdata_nxt;
      cpu_rst   <= cpu_rst_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      remaining <= remaining_nxt;
      index     <= index_nxt;
`ifdef LOADER_CHECKSUM_EN
      sum       <= sum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; expected memory writes go through a scoreboard queue.
// Define LOADER_CHECKSUM_EN for both bench and design to exercise the trailer path.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int ADDR_W = 8;
  localparam int WORD_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [WORD_W-1:0] im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  wr_t               mon_e;
  logic [WORD_W-1:0] stim_q[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (im_we !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: im_we=%b addr=%0d data=%h, no write expected", im_we, im_addr, im_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (im_we !== 1'b1 || im_addr !== mon_e.addr || im_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h", im_addr, im_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one word at negedges until in_ready is seen; it transfers on the following posedge.
  task automatic send(input logic [WORD_W-1:0] w, input bit is_data, input logic [ADDR_W-1:0] addr, output int waited);
    wr_t e;
    waited = 0;
    forever begin
      @(negedge clk);
      in_valid = 1'b1; in_data = w;
      if (in_ready === 1'b1) break;
      waited++;
      if (waited > 20) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: in_ready=%b, required 1", in_ready);
        break;
      end
    end
    if (in_ready === 1'b1 && is_data) begin
      e.addr = addr; e.data = w;
      exp_q.push_back(e);
    end
  endtask

  task automatic load_stream(input logic [WORD_W-1:0] n, input bit gaps, input logic [WORD_W-1:0] csum_delta);
    int waited;
    logic [WORD_W-1:0] s;
    s = '0;
    send(n, 1'b0, '0, waited);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (gaps) begin @(negedge clk); in_valid = 1'b0; end
      send(stim_q[i], 1'b1, ADDR_W'(i), waited);
      s = s + stim_q[i];
      if (!gaps) begin
        checks++;
        if (waited != 0) begin
          errors++;
          $display("FAIL no_stall: word %0d waited %0d cycles, required 0", i, waited);
        end
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (gaps) begin @(negedge clk); in_valid = 1'b0; end
    send(s + csum_delta, 1'b0, '0, waited);
`else
    if (csum_delta != '0) $display("note: trailer offset ignored without checksum");
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== '0 || im_wdata !== '0 ||
        cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h wd=%h cpu_rst=%b done=%b err=%b, required 0 0 0 0 1 0 0",
               in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL len_ready: in_ready=%b cpu_rst=%b, required 1 1", in_ready, cpu_rst);
    end
  endtask

  task automatic test_happy();
    apply_reset();
    stim_q = '{16'h1234, 16'hABCD, 16'h0001};
    load_stream(16'd3, 1'b0, 16'h0000);
    @(negedge clk);
    in_data = 16'hDEAD;
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL happy_flush: in_ready=%b done=%b cpu_rst=%b, required 0 0 1", in_ready, done, cpu_rst);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL happy_done: done=%b cpu_rst=%b err=%b in_ready=%b, required 1 0 0 0", done, cpu_rst, err, in_ready);
    end
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL happy_end: pending=%0d done=%b, required 0 1", exp_q.size(), done);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    stim_q = '{16'h1234, 16'hABCD, 16'h0001};
    load_stream(16'd3, 1'b1, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gaps_done: done=%b cpu_rst=%b pending=%0d, required 1 0 0", done, cpu_rst, exp_q.size());
    end
  endtask

  task automatic test_bad_len(input logic [WORD_W-1:0] n);
    int waited;
    apply_reset();
    send(n, 1'b0, '0, waited);
    @(negedge clk);
    in_data = 16'h0003;
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_len_%0d: err=%b in_ready=%b cpu_rst=%b done=%b, required 1 0 1 0", n, err, in_ready, cpu_rst, done);
    end
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_len_hold_%0d: err=%b cpu_rst=%b pending=%0d, required 1 1 0", n, err, cpu_rst, exp_q.size());
    end
  endtask

  task automatic test_full_depth();
    apply_reset();
    stim_q.delete();
    for (int i = 0; i < 256; i++) stim_q.push_back(16'(i));
    load_stream(16'd256, 1'b0, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_depth: done=%b err=%b pending=%0d, required 1 0 0", done, err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    apply_reset();
    send(16'd5, 1'b0, '0, waited);
    send(16'h1111, 1'b1, 8'd0, waited);
    send(16'h2222, 1'b1, 8'd1, waited);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== '0 || im_wdata !== '0 ||
        cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_values: rdy=%b we=%b addr=%h wd=%h cpu_rst=%b done=%b err=%b, required 0 0 0 0 1 0 0",
               in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err);
    end
    reset = 1'b0;
    stim_q = '{16'hBEEF};
    load_stream(16'd1, 1'b0, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reload: done=%b cpu_rst=%b pending=%0d, required 1 0 0", done, cpu_rst, exp_q.size());
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    apply_reset();
    stim_q = '{16'h1234, 16'hABCD, 16'h0001};
    load_stream(16'd3, 1'b0, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL csum_good: done=%b err=%b cpu_rst=%b, required 1 0 0", done, err, cpu_rst);
    end
    apply_reset();
    load_stream(16'd3, 1'b0, 16'h0001);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL csum_bad: err=%b cpu_rst=%b done=%b in_ready=%b, required 1 1 0 0", err, cpu_rst, done, in_ready);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_happy();
    test_gaps();
    test_bad_len(16'd0);
    test_bad_len(16'd257);
    test_full_depth();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
